// File: rtl/alu_cond_writeback.sv
// rtl/alu_cond_writeback.sv - ALU execute/writeback stage with NZCV condition check and multi-cycle MUL hold
module alu_cond_writeback #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        opcode_i,
  input  logic [3:0]        cond_i,
  input  logic              s_i,
  input  logic [3:0]        rd_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [3:0]        new_flag_i,
  output logic [3:0]        flag_o,
  output logic              wb_en_o,
  output logic [3:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              retire_o,
  output logic              cond_pass_o
);

  localparam logic [3:0] OP_MUL    = 4'b0010;
  localparam logic [3:0] OP_CMP    = 4'b1011;
  localparam int         CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic                s_q, s_d;
  logic [3:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          nflag_q, nflag_d;
  logic                pass_q, pass_d;
  logic [3:0]          flag_q, flag_d;
  logic                wb_en_q, wb_en_d;
  logic [3:0]          wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                retire_q, retire_d;
  logic                cond_pass_q, cond_pass_d;
  logic                accept;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = !z;
      4'h2:    cond_eval = cf;
      4'h3:    cond_eval = !cf;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = !n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = !v;
      4'h8:    cond_eval = cf & !z;
      4'h9:    cond_eval = !cf | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = !z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign in_ready_o = (state_q != MUL_WAIT);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    flag_d      = flag_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    retire_d    = 1'b0;
    cond_pass_d = 1'b0;
    if (state_q == COMMIT) begin
      retire_d    = 1'b1;
      cond_pass_d = pass_q;
      if (pass_q && (op_q <= 4'b1010)) begin
        wb_en_d   = 1'b1;
        wb_addr_d = rd_q;
        wb_data_d = result_q;
      end
      if (pass_q && (op_q <= OP_CMP) && (s_q || op_q == OP_CMP))
        flag_d = nflag_q;
    end
  end

  // Condition is checked against flag_d so a back-to-back instruction sees the committing flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    s_d      = s_q;
    rd_d     = rd_q;
    result_d = result_q;
    nflag_d  = nflag_q;
    pass_d   = pass_q;
    if (accept) begin
      op_d     = opcode_i;
      s_d      = s_i;
      rd_d     = rd_i;
      result_d = result_i;
      nflag_d  = new_flag_i;
      pass_d   = cond_eval(cond_i, flag_d);
    end
    case (state_q)
      MUL_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      end
      default: begin
        if (!accept) begin
          state_d = IDLE;
        end else if (opcode_i == OP_MUL && MUL_MULTI) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_W'(MUL_LAT - 1);
        end else begin
          state_d = COMMIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      s_q         <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      nflag_q     <= '0;
      pass_q      <= 1'b0;
      flag_q      <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      retire_q    <= 1'b0;
      cond_pass_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      s_q         <= s_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      nflag_q     <= nflag_d;
      pass_q      <= pass_d;
      flag_q      <= flag_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      retire_q    <= retire_d;
      cond_pass_q <= cond_pass_d;
    end
  end

  assign flag_o      = flag_q;
  assign wb_en_o     = wb_en_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign retire_o    = retire_q;
  assign cond_pass_o = cond_pass_q;

endmodule

// File: tb/tb_alu_cond_writeback.sv
// tb/tb_alu_cond_writeback.sv - scoreboard bench for alu_cond_writeback with directed vectors
module tb_alu_cond_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [3:0]  cond = '0;
  logic        s = 1'b0;
  logic [3:0]  rd = '0;
  logic [31:0] result = '0;
  logic [3:0]  new_flag = '0;
  logic [3:0]  flag;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        retire;
  logic        cond_pass;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        wb_en;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        pass;
    logic [3:0]  flag;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  alu_cond_writeback #(.DATA_W(32), .MUL_LAT(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .opcode_i(opcode), .cond_i(cond), .s_i(s), .rd_i(rd), .result_i(result),
    .new_flag_i(new_flag), .flag_o(flag), .wb_en_o(wb_en), .wb_addr_o(wb_addr),
    .wb_data_o(wb_data), .retire_o(retire), .cond_pass_o(cond_pass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every retire pops one expectation.
  always @(negedge clk) begin
    if (rst_n && retire) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_retire: got retire=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_cycle", 64'(cyc), 64'(e.cyc));
        chk("wb_en", 64'(wb_en), 64'(e.wb_en));
        chk("wb_addr", 64'(wb_addr), 64'(e.addr));
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("cond_pass", 64'(cond_pass), 64'(e.pass));
        chk("flag", 64'(flag), 64'(e.flag));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] c, input logic sf,
                       input logic [3:0] r, input logic [31:0] res, input logic [3:0] nf,
                       input logic push, input logic ew, input logic [3:0] ea,
                       input logic [31:0] ed, input logic ep, input logic [3:0] ef,
                       output int stalls);
    exp_t e;
    bit done = 0;
    stalls = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opcode = op; cond = c; s = sf; rd = r; result = res; new_flag = nf;
      if (in_ready) begin
        if (push) begin
          e.wb_en = ew; e.addr = ea; e.data = ed; e.pass = ep; e.flag = ef;
          e.cyc = cyc + 1 + ((op == 4'b0010) ? 3 : 1);
          sb.push_back(e);
        end
        @(posedge clk);
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected 1");
    end
  endtask

  task automatic idle_drain();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  int st;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("rst_flag", 64'(flag), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_data", 64'(wb_data), 64'd0);

    // ADD AL, S=1
    issue(4'h0, 4'hE, 1'b1, 4'd3, 32'h5, 4'b0000, 1, 1, 4'd3, 32'h5, 1, 4'b0000, st);
    // CMP -> Z, then SUB EQ passes via forwarded Z
    issue(4'hB, 4'hE, 1'b0, 4'd9, 32'h99, 4'b0100, 1, 0, 4'd3, 32'h5, 1, 4'b0100, st);
    issue(4'h1, 4'h0, 1'b0, 4'd1, 32'h11, 4'b0000, 1, 1, 4'd1, 32'h11, 1, 4'b0100, st);
    // CMP clears Z; SUB EQ must fail against forwarded flags
    issue(4'hB, 4'hE, 1'b0, 4'd9, 32'h99, 4'b0000, 1, 0, 4'd1, 32'h11, 1, 4'b0000, st);
    issue(4'h1, 4'h0, 1'b0, 4'd2, 32'h22, 4'b1111, 1, 0, 4'd1, 32'h11, 0, 4'b0000, st);
    // CMP sets Z; SUB NE fails
    issue(4'hB, 4'hE, 1'b0, 4'd9, 32'h99, 4'b0100, 1, 0, 4'd1, 32'h11, 1, 4'b0100, st);
    issue(4'h1, 4'h1, 1'b0, 4'd2, 32'h22, 4'b1111, 1, 0, 4'd1, 32'h11, 0, 4'b0100, st);
    // MUL then queued ADD MI using forwarded N
    issue(4'h2, 4'hE, 1'b1, 4'd7, 32'h30, 4'b1000, 1, 1, 4'd7, 32'h30, 1, 4'b1000, st);
    issue(4'h0, 4'h4, 1'b1, 4'd4, 32'hABCD_1234, 4'b0011, 1, 1, 4'd4, 32'hABCD_1234, 1, 4'b0011, st);
    chk("mul_stall_cycles", 64'(st), 64'd2);
    // NV never passes
    issue(4'h0, 4'hF, 1'b1, 4'd5, 32'h55, 4'b1111, 1, 0, 4'd4, 32'hABCD_1234, 0, 4'b0011, st);
    // Retire-only opcode
    issue(4'hC, 4'hE, 1'b1, 4'd6, 32'h66, 4'b0000, 1, 0, 4'd4, 32'hABCD_1234, 1, 4'b0011, st);
    // HI passes (C=1,Z=0), full-width data
    issue(4'hA, 4'h8, 1'b0, 4'd15, 32'hFFFF_FFFF, 4'b0000, 1, 1, 4'd15, 32'hFFFF_FFFF, 1, 4'b0011, st);
    // GE fails (N=0,V=1)
    issue(4'h0, 4'hA, 1'b1, 4'd8, 32'h88, 4'b0000, 1, 0, 4'd15, 32'hFFFF_FFFF, 0, 4'b0011, st);
    idle_drain();

    // Async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_flag", 64'(flag), 64'd0);
    chk("async_wb_addr", 64'(wb_addr), 64'd0);
    chk("async_wb_data", 64'(wb_data), 64'd0);
    chk("async_cond_pass", 64'(cond_pass), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during MUL_WAIT discards the MUL
    issue(4'h2, 4'hE, 1'b1, 4'd9, 32'h90, 4'b1111, 0, 0, 4'd0, 32'h0, 0, 4'b0000, st);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mul_wait_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mulrst_retire", 64'(retire), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mulrst_flag", 64'(flag), 64'd0);
    chk("mulrst_wb_addr", 64'(wb_addr), 64'd0);
    chk("mulrst_in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
